// File: rtl/vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vc_arbiter
// Description : Weighted round-robin drain of two VC FIFOs into two
//               destination FIFOs, routed by the word's top bit.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_arbiter #(
    parameter int BW     = 6,
    parameter int WEIGHT = 3,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    input  logic [BW-1:0] vc0_data,
    input  logic [BW-1:0] vc1_data,
    input  logic          d0_almost_full,
    input  logic          d1_almost_full,
    output logic          vc0_pop,
    output logic          vc1_pop,
    output logic          d0_push,
    output logic          d1_push,
    output logic [BW-1:0] d0_data,
    output logic [BW-1:0] d1_data,
    output logic          busy,
    output logic [CW-1:0] d0_count,
    output logic [CW-1:0] d1_count
);

    localparam int c_cnt_w = (WEIGHT < 1) ? 1 : $clog2(WEIGHT + 1);
    localparam logic [c_cnt_w-1:0] c_weight = c_cnt_w'(WEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    logic [c_cnt_w-1:0]   cnt_q;
    logic [c_cnt_w-1:0]   cnt_d;
    logic                 s1_valid_q;
    logic                 s1_src_q;
    logic                 d0_push_q;
    logic                 d1_push_q;
    logic [BW-1:0]        d0_data_q;
    logic [BW-1:0]        d1_data_q;
    logic [CW-1:0]        d0_count_q;
    logic [CW-1:0]        d1_count_q;

    logic                 w_can_pop;
    logic                 w_has0;
    logic                 w_has1;
    logic                 w_pop0;
    logic                 w_pop1;
    logic [BW-1:0]        w_word;
    logic                 w_to_d1;

    // Both almost-full flags gate every pop: the destination is unknown until the word is read.
    always_comb begin
        w_can_pop = (state_q == S_ARB) && enable && !d0_almost_full
                    && !d1_almost_full && !reset;
        w_has0    = !vc0_empty;
        w_has1    = !vc1_empty;
        w_pop0    = 1'b0;
        w_pop1    = 1'b0;
        cnt_d     = cnt_q;
        if (w_can_pop) begin
            if (w_has0 && w_has1) begin
                if (cnt_q < c_weight) begin
                    w_pop0 = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    w_pop1 = 1'b1;
                    cnt_d  = '0;
                end
            end else if (w_has0) begin
                w_pop0 = 1'b1;
                cnt_d  = '0;
            end else if (w_has1) begin
                w_pop1 = 1'b1;
                cnt_d  = '0;
            end
        end
    end

    assign w_word  = s1_src_q ? vc1_data : vc0_data;
    assign w_to_d1 = w_word[BW-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) state_q <= S_ARB;
                end
                S_ARB: begin
                    if (!enable) state_q <= s1_valid_q ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (enable)           state_q <= S_ARB;
                    else if (!s1_valid_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_src_q   <= 1'b0;
            d0_push_q  <= 1'b0;
            d1_push_q  <= 1'b0;
            d0_data_q  <= '0;
            d1_data_q  <= '0;
            d0_count_q <= '0;
            d1_count_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= w_pop0 | w_pop1;
            s1_src_q   <= w_pop1;
            d0_push_q  <= s1_valid_q && !w_to_d1;
            d1_push_q  <= s1_valid_q && w_to_d1;
            if (s1_valid_q && !w_to_d1) begin
                d0_data_q  <= w_word;
                d0_count_q <= d0_count_q + 1'b1;
            end
            if (s1_valid_q && w_to_d1) begin
                d1_data_q  <= w_word;
                d1_count_q <= d1_count_q + 1'b1;
            end
        end
    end

    assign vc0_pop  = w_pop0;
    assign vc1_pop  = w_pop1;
    assign d0_push  = d0_push_q;
    assign d1_push  = d1_push_q;
    assign d0_data  = d0_data_q;
    assign d1_data  = d1_data_q;
    assign d0_count = d0_count_q;
    assign d1_count = d1_count_q;
    assign busy     = !((state_q == S_IDLE) && !s1_valid_q && !d0_push_q && !d1_push_q);

endmodule
`default_nettype wire

// File: tb/tb_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_arbiter
// Description : Directed + randomized bench for vc_arbiter with FIFO models
//               and a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_arbiter;

    localparam int BW     = 6;
    localparam int WEIGHT = 3;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          vc0_empty, vc1_empty;
    logic [BW-1:0] vc0_data, vc1_data;
    logic          d0_almost_full, d1_almost_full;
    logic          vc0_pop, vc1_pop, d0_push, d1_push;
    logic [BW-1:0] d0_data, d1_data;
    logic          busy;
    logic [CW-1:0] d0_count, d1_count;

    always #5 clk = ~clk;

    vc_arbiter #(.BW(BW), .WEIGHT(WEIGHT), .CW(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_push(d0_push), .d1_push(d1_push),
        .d0_data(d0_data), .d1_data(d1_data),
        .busy(busy), .d0_count(d0_count), .d1_count(d1_count)
    );

    int checks = 0;
    int errors = 0;

    // Environment FIFO contents
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    // Reference model: mode 0 idle / 1 arbitrating / 2 draining
    int            m_mode;
    int            m_credit;
    bit            p1v, p2v;
    logic [BW-1:0] p1w, p2w;
    int            m_cnt0, m_cnt1;

    int            pops_seen, pushes_seen;
    bit            last_pop0, last_pop1;
    int            popseq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_credit = 0;
        p1v = 0; p2v = 0; p1w = '0; p2w = '0;
        m_cnt0 = 0; m_cnt1 = 0;
    endtask

    // One clock cycle; entered and left at a falling edge.
    task automatic step();
        bit            ok, h0, h1, e0, e1, dp0, dp1, inflight, exp_busy;
        logic [BW-1:0] mw;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        #1;
        h0 = (q0.size() != 0);
        h1 = (q1.size() != 0);
        ok = (m_mode == 1) && enable && !d0_almost_full && !d1_almost_full;
        e0 = 0; e1 = 0;
        if (ok && h0 && h1) begin
            e0 = (m_credit < WEIGHT);
            e1 = !e0;
        end else begin
            e0 = ok && h0;
            e1 = ok && h1 && !h0;
        end
        chk("vc0_pop", vc0_pop, e0);
        chk("vc1_pop", vc1_pop, e1);
        mw = e0 ? q0[0] : (e1 ? q1[0] : '0);
        dp0 = vc0_pop; dp1 = vc1_pop;
        last_pop0 = dp0; last_pop1 = dp1;
        if (dp0 || dp1) begin
            pops_seen++;
            popseq.push_back(dp1 ? 1 : 0);
        end
        if (e0 && h1)       m_credit = m_credit + 1;
        else if (e0 || e1)  m_credit = 0;
        inflight = p1v;
        case (m_mode)
            0: if (enable) m_mode = 1;
            1: if (!enable) m_mode = inflight ? 2 : 0;
            default: begin
                if (enable)         m_mode = 1;
                else if (!inflight) m_mode = 0;
            end
        endcase
        @(posedge clk);
        #1;
        if (dp0 && q0.size() != 0) vc0_data = q0.pop_front();
        if (dp1 && q1.size() != 0) vc1_data = q1.pop_front();
        p2v = p1v; p2w = p1w;
        p1v = e0 || e1; p1w = mw;
        if (p2v) begin
            if (p2w[BW-1]) m_cnt1 = (m_cnt1 + 1) % (1 << CW);
            else           m_cnt0 = (m_cnt0 + 1) % (1 << CW);
        end
        chk("d0_push", d0_push, p2v && !p2w[BW-1]);
        chk("d1_push", d1_push, p2v && p2w[BW-1]);
        if (p2v && !p2w[BW-1]) chk("d0_data", d0_data, p2w);
        if (p2v && p2w[BW-1])  chk("d1_data", d1_data, p2w);
        chk("d0_count", d0_count, m_cnt0);
        chk("d1_count", d1_count, m_cnt1);
        exp_busy = !(m_mode == 0 && !p1v && !p2v);
        chk("busy", busy, exp_busy);
        if (d0_push || d1_push) pushes_seen++;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse in mid-cycle; entered and left at a falling edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_vc0_pop", vc0_pop, 0);
        chk("rst_vc1_pop", vc1_pop, 0);
        chk("rst_d0_push", d0_push, 0);
        chk("rst_d1_push", d1_push, 0);
        chk("rst_d0_data", d0_data, 0);
        chk("rst_d1_data", d1_data, 0);
        chk("rst_d0_count", d0_count, 0);
        chk("rst_d1_count", d1_count, 0);
        chk("rst_busy", busy, 0);
        q0.delete(); q1.delete();
        vc0_data = '0; vc1_data = '0;
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_empty(input int max_cycles, input string tag);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || p1v || p2v) && n < max_cycles) begin
            step();
            n++;
        end
        chk(tag, (n < max_cycles), 1);
    endtask

    initial begin
        int            exp_seq[8];
        int            b0, b1, pb, pp, n;
        logic [BW-1:0] w;

        reset = 1'b1; enable = 1'b0;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        vc0_data = '0; vc1_data = '0; vc0_empty = 1'b1; vc1_empty = 1'b1;
        pops_seen = 0; pushes_seen = 0;
        model_reset();
        @(negedge clk);

        // Reset state, then idle with work pending but enable low
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w = BW'($urandom); q0.push_back(w);
            w = BW'($urandom); q1.push_back(w);
        end
        pb = pops_seen;
        repeat (20) step();
        chk("idle_no_pops", pops_seen - pb, 0);
        chk("idle_busy", busy, 0);

        // Weighting 3:1
        popseq.delete();
        enable = 1'b1;
        run_until_empty(80, "weight_timeout");
        exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
        chk("weight_npops", popseq.size(), 16);
        for (int i = 0; i < 8 && i < popseq.size(); i++) chk("weight_seq", popseq[i], exp_seq[i]);

        // Routing by top bit
        b0 = m_cnt0; b1 = m_cnt1;
        q0.push_back(6'h25);
        q0.push_back(6'h05);
        run_until_empty(20, "route_timeout");
        chk("route_d1_cnt", d1_count, (b1 + 1) % 256);
        chk("route_d0_cnt", d0_count, (b0 + 1) % 256);

        // Backpressure while VC1 streams
        for (int i = 0; i < 16; i++) begin
            w = BW'($urandom); q1.push_back(w);
        end
        repeat (3) step();
        d0_almost_full = 1'b1;
        pb = pops_seen; pp = pushes_seen;
        repeat (6) step();
        chk("bp_no_pops", pops_seen - pb, 0);
        chk("bp_pushes_le2", (pushes_seen - pp) <= 2, 1);
        d0_almost_full = 1'b0;
        step();
        chk("bp_resume", last_pop1, 1);
        run_until_empty(40, "bp_timeout");

        // Drain after enable drop
        q0.push_back(6'h11);
        step();
        chk("drain_pop", last_pop0, 1);
        enable = 1'b0;
        pp = pushes_seen;
        n = 0;
        while (busy && n < 10) begin
            step();
            n++;
        end
        chk("drain_busy_lat", n, 2);
        chk("drain_one_push", pushes_seen - pp, 1);

        // Randomized traffic with a mid-transfer reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                enable = 1'b1;
                do_reset();
            end
            enable         = ($urandom_range(0, 9) != 0);
            d0_almost_full = ($urandom_range(0, 7) == 0);
            d1_almost_full = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) != 0) begin w = BW'($urandom); q0.push_back(w); end
            if ($urandom_range(0, 2) != 0) begin w = BW'($urandom); q1.push_back(w); end
            step();
        end
        enable = 1'b1; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        run_until_empty(800, "rand_timeout");

        // Counter wrap: 256 words to D0
        do_reset();
        enable = 1'b1;
        pp = pushes_seen;
        for (int i = 0; i < 256; i++) begin
            w = BW'($urandom) & 6'h1f;
            q0.push_back(w);
        end
        run_until_empty(400, "wrap_timeout");
        chk("wrap_pushes", pushes_seen - pp, 256);
        chk("wrap_d0_count", d0_count, 0);
        chk("wrap_d1_count", d1_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
